// File: rtl/cpu_step_ctrl.sv
// Execution controller for the lab CPU: turns debounced button pulses and switches into a
// registered CPU clock-enable for halt / single-step / burst / free-run, with a PC breakpoint.
module cpu_step_ctrl #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned RUN_DIV   = 50_000_000
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic [4:0]  button_pulse,
    input  logic [7:0]  SW_OK,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic [1:0]  mode,
    output logic        halted,
    output logic        bp_hit,
    output logic [15:0] step_count
);

    localparam int unsigned DivW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast   = DivW'(RUN_DIV - 1);
    localparam logic [15:0]     BurstLen  = 16'(BURST_LEN);
    localparam logic [15:0]     BurstLast = 16'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        StHalt  = 2'b00,
        StStep  = 2'b01,
        StBurst = 2'b10,
        StRun   = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            cpu_en_q, cpu_en_d;
    logic            bp_hit_q, bp_hit_d;
    logic            first_q, first_d;
    logic [DivW-1:0] div_q, div_d;
    logic [15:0]     remaining_q, remaining_d;
    logic [15:0]     step_count_q, step_count_d;

    logic cmd_step, cmd_burst, cmd_run, cmd_clear;
    logic fast, tick, bp_match;

    assign cmd_step  = button_pulse[0];
    assign cmd_burst = button_pulse[1];
    assign cmd_run   = button_pulse[3];
    assign cmd_clear = button_pulse[4];
    assign fast      = SW_OK[7];
    assign tick      = fast || (div_q == DivLast);
    // The first tick after leaving HALT is exempt so the CPU can resume from the breakpoint.
    assign bp_match  = SW_OK[6] && (pc[7:2] == SW_OK[5:0]) && !first_q;

    logic unused_inputs;
    assign unused_inputs = ^{button_pulse[2], pc[31:8], pc[1:0]};

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q      <= StHalt;
            cpu_en_q     <= 1'b0;
            bp_hit_q     <= 1'b0;
            first_q      <= 1'b0;
            div_q        <= '0;
            remaining_q  <= '0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            bp_hit_q     <= bp_hit_d;
            first_q      <= first_d;
            div_q        <= div_d;
            remaining_q  <= remaining_d;
            step_count_q <= step_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_en_d    = 1'b0;
        bp_hit_d    = bp_hit_q;
        first_d     = first_q;
        div_d       = div_q;
        remaining_d = remaining_q;

        case (state_q)
            StHalt: begin
                div_d = '0;
                if (cmd_run || cmd_burst || cmd_step) begin
                    bp_hit_d = 1'b0;
                    first_d  = 1'b1;
                    if (cmd_run) begin
                        state_d  = StRun;
                        cpu_en_d = fast;
                    end else if (cmd_burst) begin
                        state_d     = StBurst;
                        cpu_en_d    = fast;
                        remaining_d = fast ? BurstLast : BurstLen;
                    end else begin
                        state_d  = StStep;
                        cpu_en_d = 1'b1;
                    end
                end
            end
            StStep: state_d = StHalt;
            StBurst, StRun: begin
                div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
                if (cmd_run) begin
                    state_d     = StHalt;
                    remaining_d = '0;
                end else if (state_q == StBurst && remaining_q == '0) begin
                    // remaining counts scheduled enables; zero means the last one is on cpu_en now
                    state_d = StHalt;
                end else if (tick) begin
                    if (bp_match) begin
                        state_d  = StHalt;
                        bp_hit_d = 1'b1;
                    end else begin
                        cpu_en_d = 1'b1;
                        first_d  = 1'b0;
                        if (state_q == StBurst) remaining_d = remaining_q - 16'd1;
                    end
                end
            end
            default: state_d = StHalt;
        endcase
    end

    always_comb begin
        step_count_d = step_count_q;
        if (cmd_clear) begin
            step_count_d = '0;
        end else if (cpu_en_q && step_count_q != 16'hFFFF) begin
            step_count_d = step_count_q + 16'd1;
        end
    end

    always_comb begin
        cpu_en     = cpu_en_q;
        mode       = state_q;
        halted     = (state_q == StHalt);
        bp_hit     = bp_hit_q;
        step_count = step_count_q;
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl with BURST_LEN=4, RUN_DIV=4.
module tb_cpu_step_ctrl;

    logic        clk_100mhz;
    logic        rst;
    logic [4:0]  button_pulse;
    logic [7:0]  SW_OK;
    logic [31:0] pc;
    logic        cpu_en;
    logic [1:0]  mode;
    logic        halted;
    logic        bp_hit;
    logic [15:0] step_count;

    logic pc_load;
    int   n_checks;
    int   n_errors;

    cpu_step_ctrl #(
        .BURST_LEN (4),
        .RUN_DIV   (4)
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .rst          (rst),
        .button_pulse (button_pulse),
        .SW_OK        (SW_OK),
        .pc           (pc),
        .cpu_en       (cpu_en),
        .mode         (mode),
        .halted       (halted),
        .bp_hit       (bp_hit),
        .step_count   (step_count)
    );

    initial begin
        clk_100mhz = 1'b0;
        forever #5 clk_100mhz = ~clk_100mhz;
    end

    // Toy CPU: pc advances by 4 during every cycle the enable is high.
    initial begin
        pc = 32'd0;
        forever begin
            @(negedge clk_100mhz);
            if (pc_load) pc = 32'd0;
            else if (cpu_en) pc = pc + 32'd4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    // Pulse driven in the current cycle; returns one cycle later with the pulse released.
    task automatic pulse(input logic [4:0] bits);
        button_pulse = bits;
        step_clk(1);
        button_pulse = 5'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        button_pulse = 5'b0;
        SW_OK        = 8'h00;
        pc_load      = 1'b1;
        step_clk(2);
        rst     = 1'b0;
        pc_load = 1'b0;
        step_clk(1);

        check("reset_mode", 32'(mode), 32'd0);
        check("reset_halted", 32'(halted), 32'd1);
        check("reset_cpu_en", 32'(cpu_en), 32'd0);
        check("reset_bp_hit", 32'(bp_hit), 32'd0);
        check("reset_count", 32'(step_count), 32'd0);

        // Single step, second step pulse during STEP is ignored
        pulse(5'b00001);
        check("step_en_c1", 32'(cpu_en), 32'd1);
        check("step_mode_c1", 32'(mode), 32'd1);
        button_pulse = 5'b00001;
        step_clk(1);
        button_pulse = 5'b0;
        check("step_en_c2", 32'(cpu_en), 32'd0);
        check("step_halted_c2", 32'(halted), 32'd1);
        check("step_count_c2", 32'(step_count), 32'd1);
        step_clk(1);
        check("step_ignored_en", 32'(cpu_en), 32'd0);
        check("step_ignored_count", 32'(step_count), 32'd1);

        pulse(5'b10000);
        check("clear_count", 32'(step_count), 32'd0);

        // Fast burst; coincident step+burst acts as burst
        SW_OK = 8'h80;
        pulse(5'b00011);
        for (int k = 1; k <= 4; k++) begin
            check("burst_en", 32'(cpu_en), 32'd1);
            check("burst_mode", 32'(mode), 32'd2);
            step_clk(1);
        end
        check("burst_end_en", 32'(cpu_en), 32'd0);
        check("burst_end_halted", 32'(halted), 32'd1);
        check("burst_count", 32'(step_count), 32'd4);
        step_clk(1);
        check("burst_after_en", 32'(cpu_en), 32'd0);

        // Reset mid-RUN (fast)
        pulse(5'b01000);
        step_clk(3);
        check("run_fast_mode", 32'(mode), 32'd3);
        check("run_fast_en", 32'(cpu_en), 32'd1);
        rst = 1'b1;
        step_clk(1);
        rst = 1'b0;
        check("midrst_en", 32'(cpu_en), 32'd0);
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_count", 32'(step_count), 32'd0);
        check("midrst_bp_hit", 32'(bp_hit), 32'd0);

        // Slow run: enables in cycles 5, 9; stop pulse in cycle 10
        SW_OK = 8'h00;
        pulse(5'b01000);
        for (int c = 1; c <= 14; c++) begin
            check("slow_en", 32'(cpu_en), 32'((c == 5 || c == 9) ? 1 : 0));
            if (c == 1) check("slow_mode", 32'(mode), 32'd3);
            if (c == 10) check("slow_pre_stop_halted", 32'(halted), 32'd0);
            if (c == 11) check("slow_stop_halted", 32'(halted), 32'd1);
            button_pulse = (c == 10) ? 5'b01000 : 5'b0;
            step_clk(1);
        end
        button_pulse = 5'b0;
        check("slow_count", 32'(step_count), 32'd2);

        // Breakpoint at word address 3 (pc 0x0C), fast mode
        pc_load = 1'b1;
        step_clk(1);
        pc_load = 1'b0;
        SW_OK = 8'hC3;
        pulse(5'b01000);
        for (int c = 1; c <= 3; c++) begin
            check("bp_run_en", 32'(cpu_en), 32'd1);
            step_clk(1);
        end
        check("bp_stop_en", 32'(cpu_en), 32'd0);
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_hit_set", 32'(bp_hit), 32'd1);
        check("bp_pc", pc, 32'h0C);
        step_clk(2);
        check("bp_hold_en", 32'(cpu_en), 32'd0);
        check("bp_sticky", 32'(bp_hit), 32'd1);
        pulse(5'b01000);
        check("bp_resume_en", 32'(cpu_en), 32'd1);
        check("bp_resume_pc", pc, 32'h0C);
        check("bp_resume_clear", 32'(bp_hit), 32'd0);
        pulse(5'b01000);
        check("bp_resume_stop", 32'(halted), 32'd1);

        // Counter saturation, then clear coincident with an enable
        SW_OK = 8'h80;
        pulse(5'b10000);
        check("sat_cleared", 32'(step_count), 32'd0);
        pulse(5'b01000);
        step_clk(65534);
        check("sat_fffe", 32'(step_count), 32'hFFFE);
        step_clk(1);
        check("sat_ffff", 32'(step_count), 32'hFFFF);
        step_clk(3);
        check("sat_hold", 32'(step_count), 32'hFFFF);
        check("sat_en_live", 32'(cpu_en), 32'd1);
        pulse(5'b10000);
        check("clear_wins", 32'(step_count), 32'd0);
        step_clk(1);
        check("count_after_clear", 32'(step_count), 32'd1);
        pulse(5'b01000);
        check("final_halted", 32'(halted), 32'd1);
        check("final_en", 32'(cpu_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
